peripheral_divider_param: RTL and testbench
===========================================

Name: peripheral_divider_param

Overview:
Memory-mapped divider peripheral, parametrised successor to the fixed 16-bit divider. It has a configurable operand width and an unsigned/signed mode, and returns both quotient and remainder. It adds a divide-by-zero flag, busy/done status and an optional level interrupt. It sits on the SoC peripheral bus (cs/rd/wr/addr strobes) and uses an iterative radix-2 restoring core that takes one iteration per cycle.

Parameters:
WIDTH, 16, operand/result width in bits (legal 2..32); d_in is WIDTH bits.
DOUT_W, 32, read-data bus width (must be >= WIDTH).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst==0 at a rising edge resets the block)
d_in  input  WIDTH  write data
cs  input  1  chip select
addr  input  5  byte register offset
rd  input  1  read strobe (qualified by cs)
wr  input  1  write strobe (qualified by cs)
d_out  output  DOUT_W  registered read data
irq  output  1  interrupt level, done & irq_en

Behaviour:
- Register map (byte offsets):
  - 0x04 A (dividend, RW)
  - 0x08 B (divisor, RW)
  - 0x0C CTRL: bit0 start (write-only, self-clearing), bit1 signed, bit2 irq_en
  - 0x10 QUOT (RO)
  - 0x14 STATUS (RO): bit0 done, bit1 busy, bit2 dbz
  - 0x18 REM (RO)
  - All other offsets read 0 and ignore writes.
- Reset (rst==0): A, B, CTRL, QUOT, REM, done, busy, dbz and d_out all go to 0; irq=0; FSM goes to IDLE. Reset mid-operation abandons the operation with no partial result update.
- Write (cs&wr at an edge): updates the addressed register. A and B can be written at any time; an in-flight operation uses its captured copies, so the write does not affect it.
- Start acceptance: a CTRL write with bit0=1 is a start only in IDLE or DONE. While busy, the start bit is ignored but bits 1 and 2 still update.
- Read (cs&rd at an edge): d_out loads the selected value; otherwise d_out holds.
  - QUOT/REM: sign-extended when signed=1, else zero-extended.
  - A, B, CTRL, STATUS: zero-extended.
  - cs&rd&wr together: both the write and the read occur; the read returns the pre-write value.
- FSM states IDLE, LOAD, CALC, FIX, DONE. Edge E0 accepts the start:
  - IDLE/DONE -> LOAD at E0. done, dbz and irq clear; busy=1.
  - LOAD -> CALC at E1. Core captures A, B and mode. Signed mode: operands converted to magnitudes, sign of quotient = sA^sB, sign of remainder = sA. Iteration counter = WIDTH-1.
  - LOAD with B==0 -> DONE at E1 instead: QUOT=all ones, REM=A, dbz=1, done=1, busy=0.
  - CALC: one shift/subtract per edge for WIDTH edges (E2..E(WIDTH+1)), then -> FIX.
  - FIX -> DONE at E(WIDTH+2): applies signs, writes QUOT/REM, done=1, busy=0.
  - Latency start-to-done = WIDTH+2 cycles (18 for WIDTH=16).
- Signed overflow (A = -2^(WIDTH-1), B = -1): QUOT=A, REM=0. This falls out of magnitude arithmetic on WIDTH+1-bit internal values; there is no special case.
- QUOT/REM retain previous results while busy. done and dbz are sticky until the next accepted start.

Decomposition:
- Shared package divider_pkg:
  - register offset constants (ADDR_A, ADDR_B, ADDR_CTRL, ADDR_QUOT, ADDR_STATUS, ADDR_REM)
  - CTRL/STATUS bit-index constants
  - FSM state encoding
- Sub-module div_core, parametrised by WIDTH: start/mode/a/b in, quot/rem/dbz/done out. It owns the LOAD..FIX datapath and counter. The top level owns the bus decode, register file, d_out and irq.

Test Plan:
1. WIDTH=16, unsigned. A=0x0063, B=0x0009, CTRL=0x1 -> STATUS=0x2 during the operation; STATUS=0x1 exactly 18 cycles after the start edge; QUOT=0x0000000B, REM=0x00000000.
2. Signed. A=0xFFF9 (-7), B=0x0002, CTRL=0x3 -> QUOT d_out=0xFFFFFFFD (-3), REM d_out=0xFFFFFFFF (-1).
3. Divide by zero. A=0x1234, B=0, CTRL=0x1 -> STATUS=0x5 two cycles after start; QUOT=0x0000FFFF, REM=0x00001234; a following start with B=3 clears dbz and gives QUOT=0x0611, REM=0x0001.
4. Signed overflow. A=0x8000, B=0xFFFF, CTRL=0x3 -> QUOT=0xFFFF8000, REM=0; dbz=0.
5. Interference and irq.
   - Start 99/9 with CTRL=0x5; at cycle 5 write A=0x0001 and CTRL=0x5 -> second start ignored; result still 0x000B/0x0000.
   - irq rises with done and stays high; the next accepted start drops irq.
6. Reset mid-CALC. Drive rst=0 for one edge at cycle 8 -> STATUS, QUOT, REM, d_out and irq all 0; a fresh 0x0064/0x000A operation then yields QUOT=0x000A, REM=0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared register map, control/status bit positions and FSM encoding
// for the memory-mapped divider peripheral.
package divider_pkg;

    localparam logic [4:0] ADDR_A      = 5'h04;
    localparam logic [4:0] ADDR_B      = 5'h08;
    localparam logic [4:0] ADDR_CTRL   = 5'h0C;
    localparam logic [4:0] ADDR_QUOT   = 5'h10;
    localparam logic [4:0] ADDR_STATUS = 5'h14;
    localparam logic [4:0] ADDR_REM    = 5'h18;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_DBZ  = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_core.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Captures operands in LOAD, so later register writes cannot disturb a run.
//
// state | meaning
// IDLE  | no result yet since reset, waiting for start
// LOAD  | capture operands and mode, catch divide-by-zero
// CALC  | WIDTH shift/subtract iterations on magnitudes
// FIX   | apply quotient/remainder signs, publish result
// DONE  | result valid and held, waiting for next start
module div_core
    import divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] part;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   sh;
    logic             ge;
    logic [WIDTH-1:0] part_nxt;
    logic [WIDTH-1:0] quo_nxt;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), still representable unsigned,
    // so the overflow case wraps back to A after sign fix-up.
    always_comb begin
        a_neg    = signed_mode & a[WIDTH-1];
        b_neg    = signed_mode & b[WIDTH-1];
        a_mag    = a_neg ? negate(a) : a;
        b_mag    = b_neg ? negate(b) : b;
        sh       = {part, quo[WIDTH-1]};
        ge       = (sh >= {1'b0, divisor});
        part_nxt = ge ? (sh[WIDTH-1:0] - divisor) : sh[WIDTH-1:0];
        quo_nxt  = {quo[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            divisor <= '0;
            quo     <= '0;
            part    <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        dbz   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    if (b == '0) begin
                        quot  <= '1;
                        rem   <= a;
                        dbz   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        divisor <= b_mag;
                        quo     <= a_mag;
                        part    <= '0;
                        cnt     <= CNT_W'(WIDTH - 1);
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    part <= part_nxt;
                    quo  <= quo_nxt;
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    quot  <= neg_q ? negate(quo) : quo;
                    rem   <= neg_r ? negate(part) : part;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/peripheral_divider_param.sv
// Bus-facing divider peripheral: register file, address decode, registered
// read data and level interrupt around the iterative div_core.
module peripheral_divider_param
    import divider_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DOUT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              cs,
    input  logic [4:0]        addr,
    input  logic              rd,
    input  logic              wr,
    output logic [DOUT_W-1:0] d_out,
    output logic              irq
);

    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              ctrl_signed;
    logic              ctrl_irq_en;
    logic [WIDTH-1:0]  quot;
    logic [WIDTH-1:0]  rem;
    logic              busy;
    logic              done;
    logic              dbz;

    logic              wr_en;
    logic              rd_en;
    logic [2:0]        ctrl_wr;
    logic              core_start;
    logic [2:0]        ctrl_rd;
    logic [2:0]        status_rd;
    logic [DOUT_W-1:0] rd_val;

    assign wr_en      = cs & wr;
    assign rd_en      = cs & rd;
    assign ctrl_wr    = 3'(d_in);
    // The core decides whether a start is accepted; it ignores it while busy.
    assign core_start = wr_en && (addr == ADDR_CTRL) && ctrl_wr[CTRL_START];
    assign irq        = done & ctrl_irq_en;

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk         (clk),
        .rst         (rst),
        .start       (core_start),
        .signed_mode (ctrl_signed),
        .a           (a_reg),
        .b           (b_reg),
        .quot        (quot),
        .rem         (rem),
        .busy        (busy),
        .done        (done),
        .dbz         (dbz)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            ctrl_signed <= 1'b0;
            ctrl_irq_en <= 1'b0;
        end else if (wr_en) begin
            case (addr)
                ADDR_A:    a_reg <= d_in;
                ADDR_B:    b_reg <= d_in;
                ADDR_CTRL: begin
                    ctrl_signed <= ctrl_wr[CTRL_SIGNED];
                    ctrl_irq_en <= ctrl_wr[CTRL_IRQ_EN];
                end
                default: ;
            endcase
        end
    end

    // Read mux sees register values from before any same-edge write.
    always_comb begin
        ctrl_rd                = '0;
        ctrl_rd[CTRL_SIGNED]   = ctrl_signed;
        ctrl_rd[CTRL_IRQ_EN]   = ctrl_irq_en;
        status_rd              = '0;
        status_rd[STAT_DONE]   = done;
        status_rd[STAT_BUSY]   = busy;
        status_rd[STAT_DBZ]    = dbz;
        rd_val                 = '0;
        case (addr)
            ADDR_A:      rd_val = DOUT_W'(a_reg);
            ADDR_B:      rd_val = DOUT_W'(b_reg);
            ADDR_CTRL:   rd_val = DOUT_W'(ctrl_rd);
            ADDR_STATUS: rd_val = DOUT_W'(status_rd);
            ADDR_QUOT: begin
                if (ctrl_signed) rd_val = DOUT_W'($signed(quot));
                else             rd_val = DOUT_W'(quot);
            end
            ADDR_REM: begin
                if (ctrl_signed) rd_val = DOUT_W'($signed(rem));
                else             rd_val = DOUT_W'(rem);
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_out <= '0;
        end else if (rd_en) begin
            d_out <= rd_val;
        end
    end

endmodule

// File: tb/tb_peripheral_divider_param.sv
// Directed bench for peripheral_divider_param: reads push expected values into
// a scoreboard queue, a monitor pops and compares as read data appears.
module tb_peripheral_divider_param;

    localparam logic [4:0] A_OFS  = 5'h04;
    localparam logic [4:0] B_OFS  = 5'h08;
    localparam logic [4:0] C_OFS  = 5'h0C;
    localparam logic [4:0] Q_OFS  = 5'h10;
    localparam logic [4:0] S_OFS  = 5'h14;
    localparam logic [4:0] R_OFS  = 5'h18;
    localparam logic [4:0] X_OFS  = 5'h1C;

    logic        clk;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;
    logic        irq;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_pass;
    int          n_total;
    logic        mon_seen;

    peripheral_divider_param #(.WIDTH(16), .DOUT_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic bus_rw(input logic [4:0] a, input logic [15:0] d,
                          input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    // Monitor: a read strobe seen at a rising edge means d_out is valid after it.
    initial begin
        forever begin
            @(posedge clk);
            mon_seen = cs & rd & rst;
            @(negedge clk);
            if (mon_seen) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_read: got 0x%08h expected no read", d_out);
                end else begin
                    check(name_q.pop_front(), d_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        tick(3);
        rst = 1'b1;

        // Reset state
        check("rst_dout", d_out, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        bus_read(A_OFS, 32'h0, "rst_a");
        bus_read(C_OFS, 32'h0, "rst_ctrl");
        bus_read(S_OFS, 32'h0, "rst_status");
        bus_read(Q_OFS, 32'h0, "rst_quot");

        // Register access, read-during-write, unmapped offset
        bus_write(A_OFS, 16'h0063);
        bus_rw(A_OFS, 16'h0055, 32'h0000_0063, "rw_old_a");
        bus_read(A_OFS, 32'h0000_0055, "a_after_rw");
        bus_write(A_OFS, 16'h0063);
        bus_write(X_OFS, 16'hBEEF);
        bus_read(X_OFS, 32'h0, "unmapped_read");
        bus_read(A_OFS, 32'h0000_0063, "a_no_alias");

        // 1: unsigned 99/9, latency 18
        bus_write(B_OFS, 16'h0009);
        bus_write(C_OFS, 16'h0001);          // E0
        bus_read(S_OFS, 32'h2, "t1_busy");   // E1
        tick(16);                            // E2..E17
        bus_read(S_OFS, 32'h2, "t1_busy_e18");
        bus_read(S_OFS, 32'h1, "t1_done_e19");
        bus_read(Q_OFS, 32'h0000_000B, "t1_quot");
        bus_read(R_OFS, 32'h0000_0000, "t1_rem");

        // 2: signed -7/2
        bus_write(A_OFS, 16'hFFF9);
        bus_write(B_OFS, 16'h0002);
        bus_write(C_OFS, 16'h0003);
        tick(20);
        bus_read(S_OFS, 32'h1, "t2_status");
        bus_read(Q_OFS, 32'hFFFF_FFFD, "t2_quot");
        bus_read(R_OFS, 32'hFFFF_FFFF, "t2_rem");

        // 3: divide by zero, then recovery
        bus_write(A_OFS, 16'h1234);
        bus_write(B_OFS, 16'h0000);
        bus_write(C_OFS, 16'h0001);          // E0
        tick(1);                             // E1
        bus_read(S_OFS, 32'h5, "t3_dbz_status");
        bus_read(Q_OFS, 32'h0000_FFFF, "t3_quot");
        bus_read(R_OFS, 32'h0000_1234, "t3_rem");
        bus_write(B_OFS, 16'h0003);
        bus_write(C_OFS, 16'h0001);
        bus_read(S_OFS, 32'h2, "t3_dbz_cleared");
        tick(20);
        bus_read(S_OFS, 32'h1, "t3b_status");
        bus_read(Q_OFS, 32'h0000_0611, "t3b_quot");
        bus_read(R_OFS, 32'h0000_0001, "t3b_rem");

        // 4: signed overflow
        bus_write(A_OFS, 16'h8000);
        bus_write(B_OFS, 16'hFFFF);
        bus_write(C_OFS, 16'h0003);
        tick(20);
        bus_read(S_OFS, 32'h1, "t4_status");
        bus_read(Q_OFS, 32'hFFFF_8000, "t4_quot");
        bus_read(R_OFS, 32'h0000_0000, "t4_rem");

        // 5: writes during operation, irq
        bus_write(A_OFS, 16'h0063);
        bus_write(B_OFS, 16'h0009);
        bus_write(C_OFS, 16'h0005);          // E0
        check("t5_irq_low_busy", {31'h0, irq}, 32'h0);
        tick(4);                             // E1..E4
        bus_write(A_OFS, 16'h0001);          // E5
        bus_write(C_OFS, 16'h0005);          // E6, ignored start
        tick(12);                            // E7..E18
        bus_read(S_OFS, 32'h1, "t5_done_e19");
        check("t5_irq_high", {31'h0, irq}, 32'h1);
        bus_read(Q_OFS, 32'h0000_000B, "t5_quot");
        bus_read(R_OFS, 32'h0000_0000, "t5_rem");
        tick(5);
        check("t5_irq_sticky", {31'h0, irq}, 32'h1);
        bus_read(C_OFS, 32'h4, "t5_ctrl");
        bus_write(C_OFS, 16'h0005);
        check("t5_irq_drop", {31'h0, irq}, 32'h0);
        tick(20);
        bus_read(Q_OFS, 32'h0000_0000, "t5b_quot");
        bus_read(R_OFS, 32'h0000_0001, "t5b_rem");

        // 6: reset mid-CALC
        bus_write(A_OFS, 16'h0063);
        bus_write(C_OFS, 16'h0005);          // E0
        tick(7);                             // E1..E7
        rst = 1'b0;
        tick(1);                             // E8
        rst = 1'b1;
        check("t6_dout", d_out, 32'h0);
        check("t6_irq", {31'h0, irq}, 32'h0);
        tick(20);
        check("t6_irq_late", {31'h0, irq}, 32'h0);
        bus_read(S_OFS, 32'h0, "t6_status");
        bus_read(Q_OFS, 32'h0, "t6_quot");
        bus_read(R_OFS, 32'h0, "t6_rem");
        bus_read(A_OFS, 32'h0, "t6_a");
        bus_write(A_OFS, 16'h0064);
        bus_write(B_OFS, 16'h000A);
        bus_write(C_OFS, 16'h0001);
        tick(20);
        bus_read(S_OFS, 32'h1, "t6b_status");
        bus_read(Q_OFS, 32'h0000_000A, "t6b_quot");
        bus_read(R_OFS, 32'h0000_0000, "t6b_rem");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick(1);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
